// File: rtl/traffic_ctrl_param.sv
// Parametrised two-way (NS/EW) traffic-light controller.
// Fixed phase sequence with per-direction green times, all-red clearance,
// pedestrian green shortening, night flashing mode, and a two-digit countdown
// presented as BCD and active-low 7-segment.
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous reset, active-high
//   i_ped_req   pedestrian request, one-cycle pulse (debounced upstream)
//   i_night     night-mode level
//   o_ledns     NS lamps {red,yellow,green}, active-high
//   o_ledew     EW lamps {red,yellow,green}, active-high
//   o_bcd       countdown {tens,ones} in BCD
//   o_seg1      tens digit segments {g..a}, active-low
//   o_seg0      ones digit segments {g..a}, active-low
//   o_ped_wait  pedestrian request latched and not yet served
module traffic_ctrl_param #(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned GREEN_NS      = 30,
  parameter int unsigned GREEN_EW      = 25,
  parameter int unsigned YELLOW_T      = 3,
  parameter int unsigned ALL_RED_T     = 2,
  parameter int unsigned PED_GREEN_MAX = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ped_req,
  input  logic       i_night,
  output logic [2:0] o_ledns,
  output logic [2:0] o_ledew,
  output logic [7:0] o_bcd,
  output logic [6:0] o_seg1,
  output logic [6:0] o_seg0,
  output logic       o_ped_wait
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = 7;

  typedef enum logic [2:0] {NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, NIGHT} state_t;

  state_t        state;
  logic [RW-1:0] rem;
  logic [PW-1:0] presc;
  logic          flash;
  logic          ped_latch;
  logic          tick;
  logic [7:0]    rem_bcd;

  // Phase successor in the fixed cycle.
  function automatic state_t next_phase(input state_t s);
    case (s)
      NS_G:    return NS_Y;
      NS_Y:    return AR1;
      AR1:     return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR2;
      default: return NS_G;
    endcase
  endfunction

  // Duration loaded on entry to a phase.
  function automatic logic [RW-1:0] phase_dur(input state_t s);
    case (s)
      NS_G:       return RW'(GREEN_NS);
      EW_G:       return RW'(GREEN_EW);
      NS_Y, EW_Y: return RW'(YELLOW_T);
      default:    return RW'(ALL_RED_T);
    endcase
  endfunction

  function automatic logic [2:0] ns_lamp(input state_t s);
    case (s)
      NS_G:    return 3'b001;
      NS_Y:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input state_t s);
    case (s)
      EW_G:    return 3'b001;
      EW_Y:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign rem_bcd = {4'(rem / RW'(10)), 4'(rem % RW'(10))};

  // Prescaler, phase FSM, pedestrian latch and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= AR2;
      rem        <= RW'(ALL_RED_T);
      presc      <= '0;
      flash      <= 1'b0;
      ped_latch  <= 1'b0;
      o_ledns    <= 3'b100;
      o_ledew    <= 3'b100;
      o_bcd      <= {4'(ALL_RED_T / 10), 4'(ALL_RED_T % 10)};
      o_seg1     <= seg7(4'(ALL_RED_T / 10));
      o_seg0     <= seg7(4'(ALL_RED_T % 10));
      o_ped_wait <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);

      // Outputs mirror the state held during this cycle.
      if (state == NIGHT) begin
        o_ledns <= {1'b0, flash, 1'b0};
        o_ledew <= {1'b0, flash, 1'b0};
        o_bcd   <= 8'h00;
        o_seg1  <= 7'h7F;
        o_seg0  <= 7'h7F;
      end else begin
        o_ledns <= ns_lamp(state);
        o_ledew <= ew_lamp(state);
        o_bcd   <= rem_bcd;
        o_seg1  <= seg7(rem_bcd[7:4]);
        o_seg0  <= seg7(rem_bcd[3:0]);
      end
      o_ped_wait <= ped_latch;

      if (state != NIGHT && i_night) begin
        // Night entry beats any phase advance in the same cycle.
        state     <= NIGHT;
        flash     <= 1'b1;
        ped_latch <= 1'b0;
      end else if (state == NIGHT) begin
        if (!i_night) begin
          state <= AR2;
          rem   <= RW'(ALL_RED_T);
        end else if (tick) begin
          flash <= ~flash;
        end
      end else begin
        if (i_ped_req) ped_latch <= 1'b1;
        // Green cap takes priority over the tick decrement.
        if ((state == NS_G || state == EW_G) && ped_latch &&
            rem > RW'(PED_GREEN_MAX)) begin
          rem <= RW'(PED_GREEN_MAX);
        end else if (tick) begin
          if (rem == RW'(1)) begin
            state <= next_phase(state);
            rem   <= phase_dur(next_phase(state));
            // A request arriving on the clearing cycle stays latched.
            if ((next_phase(state) == AR1 || next_phase(state) == AR2) && !i_ped_req)
              ped_latch <= 1'b0;
          end else begin
            rem <= rem - RW'(1);
          end
        end
      end
    end
  end

endmodule
